fifo_rptr_empty: RTL and testbench

- Read-side pointer and empty-flag block for the dual-clock FIFO. It is the counterpart to the write-side gray counter, which drives inc/full/gray.
- Consumes the write-domain gray pointer and synchronises it into the read domain with 2 flops.
- Maintains the read binary/gray pointer and produces the RAM read address, a registered empty flag and a registered fill level.
- Sits in the read clock domain, between the FIFO memory read port and the consumer.

---
 rtl/fifo_rptr_empty.sv | 80 ++++++++
 tb/tb_fifo_rptr_empty.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and empty/level logic for a dual-clock FIFO.
// Brings the write-domain gray pointer into the read clock domain through a
// 2-flop synchroniser. Keeps the read pointer in both binary and gray form and
// derives a registered empty flag and a registered fill level from them.
//
// Ports:
//   clk        read-domain clock, rising edge
//   reset_n    synchronous active-low reset
//   rinc       read request; ignored while empty is high
//   wptr_gray  write pointer (gray), asynchronous to clk
//   rptr_gray  registered read pointer (gray), sent to the write domain
//   raddr      registered RAM read address (low ADDRSIZE bits of rbin)
//   empty      registered FIFO-empty flag
//   rlevel     registered number of entries available, 0..2^ADDRSIZE
module fifo_rptr_empty #(
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr_gray,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                empty,
  output logic [ADDRSIZE:0]   rlevel
);

  logic [ADDRSIZE:0] wq1;
  logic [ADDRSIZE:0] wq2;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbin_next;
  logic [ADDRSIZE:0] rgray_next;
  logic [ADDRSIZE:0] wbin_s;
  logic              rd;

  // The registered empty gates the read, so no request can pass the last word.
  assign rd = rinc & ~empty;

  always_comb begin
    rbin_next  = rbin + {{ADDRSIZE{1'b0}}, rd};
    rgray_next = (rbin_next >> 1) ^ rbin_next;
  end

  // Gray to binary: each bit is the XOR of gray bits from itself up to the MSB.
  always_comb begin
    wbin_s = '0;
    for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
      wbin_s[i] = ^(wq2 >> i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wptr_gray;
      wq2 <= wq1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      raddr     <= '0;
      empty     <= 1'b1;
      rlevel    <= '0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= rgray_next;
      raddr     <= rbin_next[ADDRSIZE-1:0];
      // Compared against the pre-edge wq2: a concurrent write can only make
      // empty pessimistic, never falsely clear it.
      empty     <= (rgray_next == wq2);
      rlevel    <= wbin_s - rbin_next;
    end
  end

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Directed bench for fifo_rptr_empty (ADDRSIZE=4): reset, synchroniser
// latency, drain to empty, 32-read wrap, full level and reset mid-operation.
module tb_fifo_rptr_empty;

  localparam int unsigned AW = 4;

  logic          clk;
  logic          reset_n;
  logic          rinc;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   rptr_gray;
  logic [AW-1:0] raddr;
  logic          empty;
  logic [AW:0]   rlevel;

  int n_checks;
  int n_pass;

  fifo_rptr_empty #(.ADDRSIZE(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rinc      (rinc),
    .wptr_gray (wptr_gray),
    .rptr_gray (rptr_gray),
    .raddr     (raddr),
    .empty     (empty),
    .rlevel    (rlevel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  // One rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_all(input string tag, input logic [AW:0] g,
                           input logic [AW-1:0] a, input logic e,
                           input logic [AW:0] l);
    check({tag, ".rptr_gray"}, 32'(rptr_gray), 32'(g));
    check({tag, ".raddr"},     32'(raddr),     32'(a));
    check({tag, ".empty"},     32'(empty),     32'(e));
    check({tag, ".rlevel"},    32'(rlevel),    32'(l));
  endtask

  initial begin
    logic [AW:0] prev_g;
    logic [AW:0] rb;
    n_checks  = 0;
    n_pass    = 0;

    // 1. Reset with activity on inputs
    reset_n   = 1'b0;
    rinc      = 1'b1;
    wptr_gray = 5'b00101;
    tick();
    tick();
    check_all("reset", 5'b00000, 4'd0, 1'b1, 5'd0);

    // 2. Sync latency: wptr bin 2
    reset_n   = 1'b1;
    rinc      = 1'b0;
    wptr_gray = 5'b00011;
    tick();
    check("sync.e1.empty", 32'(empty), 32'd1);
    check("sync.e1.rlevel", 32'(rlevel), 32'd0);
    tick();
    check("sync.e2.empty", 32'(empty), 32'd1);
    tick();
    check("sync.e3.empty", 32'(empty), 32'd0);
    check("sync.e3.rlevel", 32'(rlevel), 32'd2);

    // 3. Drain to empty, third read blocked
    rinc = 1'b1;
    tick();
    check_all("drain.e1", 5'b00001, 4'd1, 1'b0, 5'd1);
    tick();
    check_all("drain.e2", 5'b00011, 4'd2, 1'b1, 5'd0);
    tick();
    check_all("drain.e3", 5'b00011, 4'd2, 1'b1, 5'd0);
    rinc = 1'b0;

    // 4. Wrap: restart from 0, two laps of 16 reads each
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_all("wrap.rst", 5'b00000, 4'd0, 1'b1, 5'd0);
    wptr_gray = 5'b11000;                 // bin 16
    tick(); tick(); tick();
    check("wrap.lap0.rlevel", 32'(rlevel), 32'd16);
    check("wrap.lap0.empty", 32'(empty), 32'd0);
    prev_g = rptr_gray;
    rinc   = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      rb = 5'(k);
      check("wrap.a.gray", 32'(rptr_gray), 32'(bin2gray(rb)));
      check("wrap.a.raddr", 32'(raddr), 32'(k % 16));
      check("wrap.a.rlevel", 32'(rlevel), 32'(16 - k));
      check("wrap.a.empty", 32'(empty), 32'(k == 16));
      check("wrap.a.onebit", 32'($countones(prev_g ^ rptr_gray)), 32'd1);
      prev_g = rptr_gray;
    end
    check("wrap.at16.gray", 32'(rptr_gray), 32'(5'b11000));
    rinc      = 1'b0;
    wptr_gray = 5'b00000;                 // bin 32 (mod 32 = 0)
    tick(); tick(); tick();
    check("wrap.lap1.rlevel", 32'(rlevel), 32'd16);
    check("wrap.lap1.empty", 32'(empty), 32'd0);
    rinc = 1'b1;
    for (int k = 17; k <= 32; k++) begin
      tick();
      rb = 5'(k);
      check("wrap.b.gray", 32'(rptr_gray), 32'(bin2gray(rb)));
      check("wrap.b.raddr", 32'(raddr), 32'(k % 16));
      check("wrap.b.rlevel", 32'(rlevel), 32'(32 - k));
      check("wrap.b.empty", 32'(empty), 32'(k == 32));
      check("wrap.b.onebit", 32'($countones(prev_g ^ rptr_gray)), 32'd1);
      prev_g = rptr_gray;
      if (k == 31) check("wrap.at31.gray", 32'(rptr_gray), 32'(5'b10000));
    end
    check_all("wrap.end", 5'b00000, 4'd0, 1'b1, 5'd0);
    rinc = 1'b0;

    // 5. Full level with equal address, different lap
    wptr_gray = 5'b11000;                 // bin 16
    tick(); tick();
    check("full.e2.rlevel", 32'(rlevel), 32'd0);
    tick();
    check_all("full.e3", 5'b00000, 4'd0, 1'b0, 5'd16);
    rinc = 1'b1;
    tick();
    check_all("full.rd1", 5'b00001, 4'd1, 1'b0, 5'd15);
    rinc = 1'b0;

    // 6. Reset mid-operation
    wptr_gray = 5'b00101;                 // bin 6, rbin is 1
    tick(); tick(); tick();
    check("midrst.pre.rlevel", 32'(rlevel), 32'd5);
    rinc    = 1'b1;
    reset_n = 1'b0;
    tick();
    check_all("midrst.rst", 5'b00000, 4'd0, 1'b1, 5'd0);
    reset_n = 1'b1;
    rinc    = 1'b0;
    tick();
    check("midrst.e1.rlevel", 32'(rlevel), 32'd0);
    check("midrst.e1.empty", 32'(empty), 32'd1);
    tick();
    check("midrst.e2.rlevel", 32'(rlevel), 32'd0);
    check("midrst.e2.empty", 32'(empty), 32'd1);
    tick();
    check("midrst.e3.rlevel", 32'(rlevel), 32'd6);
    check("midrst.e3.empty", 32'(empty), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
